// File: rtl/mdu_alu.sv
// Execute-stage ALU with valid/ready handshake, single-cycle integer ops and a
// sequential multiply/divide unit that owns the architectural HI/LO registers.
module mdu_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [15:0]      immediate,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             branch,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_FIX} state_t;

  state_t r_state, w_state_nxt;

  logic             r_out_valid, r_branch, r_illegal;
  logic [WIDTH-1:0] r_result, r_hi, r_lo;
  logic [WIDTH-1:0] r_a, r_b, r_m, r_acc_hi, r_acc_lo;
  logic             r_signed, r_div, r_neg_q, r_neg_r;
  logic [CNT_W-1:0] r_cnt;

  logic signed [15:0] w_imm_s;
  logic signed [31:0] w_lui32;
  logic [WIDTH-1:0]   w_sext, w_zext, w_boff, w_lui, w_addr;
  logic [WIDTH-1:0]   w_res;
  logic               w_br, w_ill, w_is_md, w_accept;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_sum, w_shift, w_diff;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0]   w_hi_nxt, w_lo_nxt;

  assign in_ready  = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign branch    = r_branch;
  assign illegal   = r_illegal;
  assign hi        = r_hi;
  assign lo        = r_lo;

  // Immediate forms; sized casts of signed sources sign-extend to WIDTH.
  assign w_imm_s = immediate;
  assign w_lui32 = {immediate, 16'h0000};
  assign w_sext  = WIDTH'(w_imm_s);
  assign w_zext  = WIDTH'(immediate);
  assign w_boff  = w_sext << 2;
  assign w_lui   = WIDTH'(w_lui32);
  assign w_addr  = rs_val + w_sext;

  // Single-cycle decode and evaluate.
  always_comb begin
    w_res   = '0;
    w_br    = 1'b0;
    w_ill   = 1'b0;
    w_is_md = 1'b0;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100000: w_res = rs_val + rt_val;
          6'b100010: w_res = rs_val - rt_val;
          6'b100100: w_res = rs_val & rt_val;
          6'b100101: w_res = rs_val | rt_val;
          6'b100111: w_res = ~(rs_val | rt_val);
          6'b101010: w_res = WIDTH'($signed(rs_val) < $signed(rt_val));
          6'b010000: w_res = r_hi;
          6'b010010: w_res = r_lo;
          6'b011000, 6'b011001, 6'b011010, 6'b011011: w_is_md = 1'b1;
          default:   w_ill = 1'b1;
        endcase
      end
      6'b001000: w_res = w_addr;
      6'b001100: w_res = rs_val & w_zext;
      6'b001101: w_res = rs_val | w_zext;
      6'b001010: w_res = WIDTH'($signed(rs_val) < $signed(w_sext));
      6'b001111: w_res = w_lui;
      6'b100000, 6'b100001, 6'b100011,
      6'b101000, 6'b101001, 6'b101011: w_res = w_addr;
      6'b000100: if (rs_val == rt_val) begin w_br = 1'b1; w_res = w_boff; end
      6'b000101: if (rs_val != rt_val) begin w_br = 1'b1; w_res = w_boff; end
      6'b000001: if (!rs_val[WIDTH-1]) begin w_br = 1'b1; w_res = w_boff; end
      default:   w_ill = 1'b1;
    endcase
  end

  // Operand magnitudes and per-iteration arithmetic.
  assign w_a_neg = r_signed && r_a[WIDTH-1];
  assign w_b_neg = r_signed && r_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -r_a : r_a;
  assign w_b_mag = w_b_neg ? -r_b : r_b;
  assign w_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_m} : '0);
  assign w_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_m};
  assign w_prod  = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

  // Sign fix-up and divide-by-zero override for the HI/LO write.
  always_comb begin
    w_hi_nxt = w_prod_fix[2*WIDTH-1:WIDTH];
    w_lo_nxt = w_prod_fix[WIDTH-1:0];
    if (r_div) begin
      if (r_m == '0) begin
        w_hi_nxt = r_a;
        w_lo_nxt = '1;
      end else begin
        w_hi_nxt = r_neg_r ? -r_acc_hi : r_acc_hi;
        w_lo_nxt = r_neg_q ? -r_acc_lo : r_acc_lo;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_is_md) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = S_ITER;
      S_ITER: if (r_cnt == LAST_ITER) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Multiply/divide datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_signed <= 1'b0;
      r_div    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept && w_is_md) begin
          r_a      <= rs_val;
          r_b      <= rt_val;
          r_signed <= ~funct[0];
          r_div    <= funct[1];
        end
        S_LOAD: begin
          r_acc_hi <= '0;
          r_acc_lo <= w_a_mag;
          r_m      <= w_b_mag;
          r_neg_q  <= w_a_neg ^ w_b_neg;
          r_neg_r  <= w_a_neg;
          r_cnt    <= '0;
        end
        S_ITER: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (!r_div) begin
            {r_acc_hi, r_acc_lo} <= {w_sum, r_acc_lo[WIDTH-1:1]};
          end else if (!w_diff[WIDTH]) begin
            r_acc_hi <= w_diff[WIDTH-1:0];
            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            r_acc_hi <= w_shift[WIDTH-1:0];
            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  // Result register and architectural HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_branch    <= 1'b0;
      r_illegal   <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else if (w_accept && !w_is_md) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_branch    <= w_br;
      r_illegal   <= w_ill;
    end else if (r_state == S_FIX) begin
      r_out_valid <= 1'b1;
      r_result    <= '0;
      r_branch    <= 1'b0;
      r_illegal   <= 1'b0;
      r_hi        <= w_hi_nxt;
      r_lo        <= w_lo_nxt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mdu_alu.sv
// Self-checking bench for mdu_alu: directed cases from the plan plus randomized
// traffic compared against a plain-arithmetic reference model.
module tb_mdu_alu;
  localparam int unsigned W = 32;

  typedef struct {
    logic [31:0] res;
    logic        br;
    logic        ill;
    logic [31:0] hi;
    logic [31:0] lo;
    int          acc;
    int          lat;
    bit          md;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [5:0]  opcode = '0, funct = '0;
  logic [31:0] rs_val = '0, rt_val = '0, result, hi, lo;
  logic [15:0] immediate = '0;
  logic        branch, illegal;

  logic        in_valid64 = 1'b0, in_ready64, out_valid64, branch64, illegal64;
  logic [5:0]  opcode64 = '0, funct64 = '0;
  logic [63:0] rs64 = '0, rt64 = '0, result64, hi64, lo64;

  always #5 clk = ~clk;

  mdu_alu #(.WIDTH(32), .CNT_W(6)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .rs_val(rs_val), .rt_val(rt_val),
    .immediate(immediate), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .branch(branch), .illegal(illegal), .hi(hi), .lo(lo)
  );

  mdu_alu #(.WIDTH(64), .CNT_W(7)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
    .opcode(opcode64), .funct(funct64), .rs_val(rs64), .rt_val(rt64),
    .immediate(16'h0000), .out_valid(out_valid64), .out_ready(1'b1),
    .result(result64), .branch(branch64), .illegal(illegal64), .hi(hi64), .lo(lo64)
  );

  int          cyc = 0;
  int          n_checks = 0, n_errors = 0;
  int          ready_mode = 0;
  exp_t        q[$];
  bit          front_seen = 1'b0;
  logic [31:0] mhi = '0, mlo = '0;
  logic [31:0] last_res = '0, last_hi = '0, last_lo = '0;
  logic        last_br = 1'b0, last_ill = 1'b0;

  logic [5:0] rfun [0:7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h10, 6'h12};
  logic [5:0] iops [0:13] = '{6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h0f, 6'h20, 6'h21,
                               6'h23, 6'h28, 6'h29, 6'h2b, 6'h04, 6'h05, 6'h01};

  always @(posedge clk) cyc = cyc + 1;

  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: condition not met (actual 0, required 1)", name);
  endtask

  // Reference model: expected outputs straight from the instruction semantics.
  task automatic model(input logic [5:0] opc, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] imm, output exp_t e);
    logic [31:0] sext, zext, boff;
    logic signed [63:0] sp;
    logic [63:0] up;
    sext = {{16{imm[15]}}, imm};
    zext = {16'h0000, imm};
    boff = sext << 2;
    e.res = '0; e.br = 1'b0; e.ill = 1'b0; e.md = 1'b0; e.lat = 1; e.acc = 0;
    case (opc)
      6'h00: case (fn)
        6'h20: e.res = a + b;
        6'h22: e.res = a - b;
        6'h24: e.res = a & b;
        6'h25: e.res = a | b;
        6'h27: e.res = ~(a | b);
        6'h2a: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h10: e.res = mhi;
        6'h12: e.res = mlo;
        6'h18: begin
          sp = 64'($signed(a)) * 64'($signed(b));
          {mhi, mlo} = sp; e.md = 1'b1;
        end
        6'h19: begin
          up = 64'(a) * 64'(b);
          {mhi, mlo} = up; e.md = 1'b1;
        end
        6'h1a: begin
          e.md = 1'b1;
          if (b == 0) begin mlo = '1; mhi = a; end
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin mlo = a; mhi = '0; end
          else begin mlo = $signed(a) / $signed(b); mhi = $signed(a) % $signed(b); end
        end
        6'h1b: begin
          e.md = 1'b1;
          if (b == 0) begin mlo = '1; mhi = a; end
          else begin mlo = a / b; mhi = a % b; end
        end
        default: e.ill = 1'b1;
      endcase
      6'h08: e.res = a + sext;
      6'h0c: e.res = a & zext;
      6'h0d: e.res = a | zext;
      6'h0a: e.res = ($signed(a) < $signed(sext)) ? 32'd1 : 32'd0;
      6'h0f: e.res = {imm, 16'h0000};
      6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2b: e.res = a + sext;
      6'h04: if (a == b) begin e.br = 1'b1; e.res = boff; end
      6'h05: if (a != b) begin e.br = 1'b1; e.res = boff; end
      6'h01: if (!a[31]) begin e.br = 1'b1; e.res = boff; end
      default: e.ill = 1'b1;
    endcase
    if (e.md) e.lat = W + 3;
    e.hi = mhi;
    e.lo = mlo;
  endtask

  // Compare process: every cycle a result is presented, plus idle HI/LO and busy in_ready.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) fail("spurious_out_valid");
        else begin
          if (!front_seen) begin
            chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
            front_seen = 1'b1;
          end
          chk("result", 64'(result), 64'(q[0].res));
          chk("branch", 64'(branch), 64'(q[0].br));
          chk("illegal", 64'(illegal), 64'(q[0].ill));
          chk("hi", 64'(hi), 64'(q[0].hi));
          chk("lo", 64'(lo), 64'(q[0].lo));
          if (out_ready) begin
            last_res = result; last_br = branch; last_ill = illegal;
            last_hi = hi; last_lo = lo;
            void'(q.pop_front());
            front_seen = 1'b0;
          end
        end
      end else if (q.size() > 0) begin
        if (cyc - q[0].acc > q[0].lat) begin
          fail("result_timeout");
          void'(q.pop_front());
          front_seen = 1'b0;
        end else if (cyc > q[0].acc && q[0].md) begin
          chk("in_ready_busy", 64'(in_ready), 64'(0));
        end
      end else begin
        chk("hi_idle", 64'(hi), 64'(mhi));
        chk("lo_idle", 64'(lo), 64'(mlo));
      end
    end
  end

  // Present one op, wait (bounded) for acceptance, log the expectation.
  task automatic issue(input logic [5:0] opc, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] imm, output int acc);
    exp_t e;
    int   n;
    opcode = opc; funct = fn; rs_val = a; rt_val = b; immediate = imm;
    in_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 500);
    if (!in_ready) begin
      in_valid = 1'b0;
      fail("accept_timeout");
    end else begin
      model(opc, fn, a, b, imm, e);
      e.acc = cyc;
      q.push_back(e);
    end
    acc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 500) begin @(negedge clk); n++; end
    if (q.size() > 0) begin
      fail("drain_timeout");
      q.delete();
      front_seen = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rv();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          acc;
    int          accs [0:3];
    int          k, n;
    logic [5:0]  ro, rf;
    logic [31:0] ra, rb;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_branch_illegal", 64'({branch, illegal}), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // addi with consumer stalled: result must hold and block further accepts
    ready_mode = 2;
    issue(6'h08, 6'h00, 32'h5, 32'h0, 16'hFFFF, acc);
    repeat (3) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_result", 64'(result), 64'h4);
      chk("hold_in_ready", 64'(in_ready), 64'(0));
    end
    ready_mode = 0;
    drain();
    chk("addi_lit", 64'(last_res), 64'h4);
    chk("addi_ill_lit", 64'(last_ill), 64'(0));

    issue(6'h04, 6'h00, 32'd7, 32'd7, 16'h0003, acc); drain();
    chk("beq_br_lit", 64'(last_br), 64'(1));
    chk("beq_res_lit", 64'(last_res), 64'hC);
    issue(6'h01, 6'h00, 32'h8000_0000, 32'h0, 16'h0003, acc); drain();
    chk("bgez_br_lit", 64'(last_br), 64'(0));
    chk("bgez_res_lit", 64'(last_res), 64'(0));

    issue(6'h00, 6'h18, 32'hFFFF_FFFE, 32'd3, 16'h0, acc); drain();
    chk("mult_hi_lit", 64'(last_hi), 64'hFFFF_FFFF);
    chk("mult_lo_lit", 64'(last_lo), 64'hFFFF_FFFA);
    issue(6'h00, 6'h12, 32'h0, 32'h0, 16'h0, acc); drain();
    chk("mflo_lit", 64'(last_res), 64'hFFFF_FFFA);

    issue(6'h00, 6'h1a, 32'hFFFF_FFF9, 32'd2, 16'h0, acc); drain();
    chk("div_lo_lit", 64'(last_lo), 64'hFFFF_FFFD);
    chk("div_hi_lit", 64'(last_hi), 64'hFFFF_FFFF);
    issue(6'h00, 6'h1b, 32'd7, 32'd0, 16'h0, acc); drain();
    chk("divu0_lo_lit", 64'(last_lo), 64'hFFFF_FFFF);
    chk("divu0_hi_lit", 64'(last_hi), 64'h7);
    issue(6'h00, 6'h1a, 32'h8000_0000, 32'hFFFF_FFFF, 16'h0, acc); drain();
    chk("divmin_lo_lit", 64'(last_lo), 64'h8000_0000);
    chk("divmin_hi_lit", 64'(last_hi), 64'h0);

    issue(6'h3F, 6'h00, 32'h1234, 32'h5678, 16'h0, acc); drain();
    chk("illegal_lit", 64'(last_ill), 64'(1));
    chk("illegal_res_lit", 64'(last_res), 64'(0));

    issue(6'h0f, 6'h00, 32'h0, 32'h0, 16'h8001, acc); drain();
    chk("lui_lit", 64'(last_res), 64'h8001_0000);

    // back-to-back accepts with the consumer always ready
    for (int i = 0; i < 4; i++) issue(6'h00, 6'h20, 32'(i), 32'(10 * i), 16'h0, accs[i]);
    for (int i = 1; i < 4; i++) chk("b2b_spacing", 64'(accs[i] - accs[i-1]), 64'(1));
    drain();

    // randomized traffic with a randomly stalling consumer
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 99);
      ra = rv();
      rb = ($urandom_range(0, 3) == 0) ? ra : rv();
      if (k < 25) begin
        ro = 6'h00; rf = 6'(6'h18 + $urandom_range(0, 3));
      end else if (k < 30) begin
        ro = 6'(6'h00 + $urandom_range(0, 63)); rf = 6'($urandom_range(0, 63));
      end else if (k < 60) begin
        ro = 6'h00; rf = rfun[$urandom_range(0, 7)];
      end else begin
        ro = iops[$urandom_range(0, 13)]; rf = 6'($urandom_range(0, 63));
      end
      issue(ro, rf, ra, rb, 16'($urandom_range(0, 65535)), acc);
    end
    ready_mode = 0;
    drain();

    // reset in the middle of a divide
    issue(6'h00, 6'h1b, 32'd100, 32'd3, 16'h0, acc);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    q.delete(); front_seen = 1'b0; mhi = '0; mlo = '0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'(0));
    chk("midrst_result", 64'(result), 64'(0));
    chk("midrst_hi", 64'(hi), 64'(0));
    chk("midrst_lo", 64'(lo), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    // WIDTH=64 multiply: latency 67
    opcode64 = 6'h00; funct64 = 6'h18;
    rs64 = 64'hFFFF_FFFF_FFFF_FFFE; rt64 = 64'd3; in_valid64 = 1'b1;
    @(negedge clk);
    chk("w64_in_ready", 64'(in_ready64), 64'(1));
    @(posedge clk); #1 in_valid64 = 1'b0;
    n = 1;
    while (!out_valid64 && n < 200) begin @(posedge clk); #1; n++; end
    chk("w64_latency", 64'(n), 64'd67);
    chk("w64_hi", hi64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("w64_lo", lo64, 64'hFFFF_FFFF_FFFF_FFFA);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mdu_alu.md
Name: mdu_alu

Overview:
- Parametrised, registered successor to the datapath ALU, with a valid/ready handshake on both input and output.
- Executes the existing R-type, I-type, load/store-address and branch operations in one cycle.
- Adds a sequential multiply/divide unit (mult, multu, div, divu) that writes architectural HI/LO registers, read back with mfhi/mflo.
- Sits in the execute stage between register-file read and memory/writeback; the stage stalls on in_ready low.

Parameters:
- WIDTH, 32: datapath width in bits; legal values are even and >= 32.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation present
- in_ready  out  1  block accepts an operation this cycle
- opcode  in  6  instruction opcode
- funct  in  6  R-type function field
- rs_val  in  WIDTH  rs operand
- rt_val  in  WIDTH  rt operand
- immediate  in  16  instruction immediate
- out_valid  out  1  result/branch valid
- out_ready  in  1  consumer takes the result
- result  out  WIDTH  ALU result, address, branch offset or HI/LO read
- branch  out  1  branch taken; qualified by out_valid
- illegal  out  1  unsupported opcode/funct; qualified by out_valid
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid, result, branch, illegal, hi, lo, counter all 0.
  - Aborts any operation in flight, including mid-iteration.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - An operation is accepted on a cycle with in_valid && in_ready.
  - out_valid, result, branch and illegal hold stable until out_ready is sampled high.
  - Accepting a new op in the same cycle the old result is taken is allowed, giving back-to-back single-cycle throughput.
- Extension rules:
  - sext = immediate sign-extended to WIDTH.
  - zext = immediate zero-extended to WIDTH.
  - boff = sext shifted left 2.
  - lui result = immediate at bits [31:16], zeros below, sign-extended from bit 31 when WIDTH > 32.
- Single-cycle ops (out_valid the cycle after accept):
  - opcode 000000: add 100000, sub 100010, and 100100, or 100101, nor 100111, slt 101010 (signed); mfhi 010000 (result=hi), mflo 010010 (result=lo). Add/sub wrap modulo 2^WIDTH; no overflow trap.
  - I-type: addi 001000 (+sext), andi 001100 and ori 001101 (zext), slti 001010 (signed vs sext), lui 001111.
  - Address ops (rs+sext): lb 100000, lh 100001, lw 100011, sb 101000, sh 101001, sw 101011.
  - Branches, each with result=boff: beq 000100 (taken if rs==rt), bne 000101 (taken if rs!=rt), bgez 000001 (taken if signed rs>=0). Not taken: branch=0, result=0.
  - Any other opcode/funct: result=0, branch=0, illegal=1, out_valid still asserted.
- Multi-cycle ops (funct under opcode 000000): mult 011000, multu 011001, div 011010, divu 011011.
  - FSM: IDLE -> LOAD -> ITER -> FIX -> IDLE.
  - LOAD: capture operands; signed ops convert to magnitudes; record result signs.
  - ITER: exactly WIDTH cycles, one bit per cycle. Multiply is shift-add into a 2*WIDTH product; divide is restoring shift-subtract.
  - FIX: negate the product if signs differ. Negate the quotient if signs differ; the remainder takes the dividend sign. Write HI/LO; out_valid asserts the next cycle with result=0 and branch=0.
  - Latency accept -> out_valid is WIDTH+3 cycles (35 for WIDTH=32). in_ready stays 0 throughout.
  - Multiply: HI = upper WIDTH bits of the product, LO = lower WIDTH bits.
  - Divide: LO = quotient, HI = remainder.
  - Divide by zero (signed or unsigned): LO = all ones, HI = rs_val.
  - Signed div MIN/-1: LO = MIN, HI = 0.
- hi/lo change only at FIX and at reset; mfhi/mflo after mult/div return the new values.

Test Plan:
- Reset then addi, rs=0x00000005, imm=0xFFFF -> next cycle out_valid=1, result=0x00000004, illegal=0; hold out_ready=0 for 3 cycles -> result stable, in_ready=0.
- beq, rs=rt=7, imm=0x0003 -> branch=1, result=0x0000000C. Then bgez, rs=0x80000000 -> branch=0.
- mult, rs=0xFFFFFFFE, rt=3 -> out_valid 35 cycles after accept, hi=0xFFFFFFFF, lo=0xFFFFFFFA. Follow with mflo -> result=0xFFFFFFFA.
- div, rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu, rs=7, rt=0 -> lo=0xFFFFFFFF, hi=7.
- Deassert rst_n at iteration 10 of divu -> all outputs 0 immediately, in_ready=1 after release, hi/lo=0.
- opcode 111111 -> illegal=1, result=0. Back-to-back add ops with out_ready=1 -> one result per cycle. Repeat the mult case with WIDTH=64 (latency 67).
